cdc_toggle_tx: RTL and testbench

- Source-domain transmitter for a two-phase toggle req/ack crossing.
- Accepts one data word per transfer on a valid/ready interface, presents it on tx_data and toggles tx_req.
- Waits until the far side's ack toggle is resynchronised into this domain, then accepts the next word.
- The far side receives tx_req through a two-flop synchroniser and returns rx_ack as a level equal to the last req it consumed. This block is the sending end of that link.

---
 rtl/cdc_pkg.sv | 13 +
 rtl/sync_ff_chain.sv | 30 +++
 rtl/cdc_toggle_tx.sv | 117 +++++++++++
 tb/tb_cdc_toggle_tx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and limits for the toggle req/ack crossing.
// Used by the transmitter and by the synchroniser chain it shares with the receiver.
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop level synchroniser for a single asynchronous bit.
// Only the last stage is exposed, so nothing downstream can see a metastable flop.
module sync_ff_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Out-of-range depths are pulled back into the supported 2..4 window.
  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                     (STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : STAGES;

  logic [N-1:0] ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/cdc_toggle_tx.sv
// Sending end of a two-phase toggle req/ack crossing with an optional watchdog.
// state | meaning
// IDLE  | no transfer outstanding, in_ready=1, next valid word is launched
// WAIT  | tx_req toggled, holding tx_data until synchronised ack matches tx_req
module cdc_toggle_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  tx_state_e        state, state_nx;
  logic             ack_s;
  logic             accept;
  logic             ack_done;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_set;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx_ack),
    .q       (ack_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    ack_done = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (ack_s == tx_req) begin
          ack_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_req  <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= ack_done;
      if (accept) begin
        tx_req  <= ~tx_req;
        tx_data <= in_data;
      end
    end
  end

  // Watchdog only flags; the transfer keeps waiting so req/ack parity is never lost.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign err_set = (TIMEOUT > 0) && busy && (cnt_inc == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// Self-checking bench for cdc_toggle_tx: far-side responder, behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdc_toggle_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 10;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          rx_ack   = 1'b0;
  logic          err_clr  = 1'b0;
  logic          in_ready, tx_req, done, busy, err;
  logic [DW-1:0] tx_data;

  always #5 clock = ~clock;

  cdc_toggle_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .rx_ack   (rx_ack),
    .done     (done),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Far side: logs each new request word and echoes the req level after ack_delay cycles.
  bit            auto_ack  = 1'b0;
  int            ack_delay = 2;
  int            spur_req  = 0;
  int            spur_done = 0;
  int            cd        = -1;
  bit            last_seen = 1'b0;
  bit            pend      = 1'b0;
  logic [DW-1:0] rx_log[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      last_seen = 1'b0;
      rx_ack    = 1'b0;
      cd        = -1;
      spur_done = spur_req;
    end else begin
      if (spur_req != spur_done) begin
        rx_ack    = ~rx_ack;
        spur_done = spur_req;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rx_ack = pend;
          cd     = -1;
        end
      end
      if (auto_ack && cd < 0 && tx_req != last_seen) begin
        last_seen = tx_req;
        pend      = tx_req;
        rx_log.push_back(tx_data);
        if (ack_delay == 0) rx_ack = tx_req;
        else cd = ack_delay;
      end
    end
  end

  // Behavioural model: ack is rx_ack as seen SS edges ago; watchdog counts edges since accept.
  bit            m_wait, m_req, m_done, m_err;
  logic [DW-1:0] m_data;
  bit            samp[$];
  int            cyc     = 0;
  int            acc_cyc = 0;

  task automatic model_reset();
    m_wait = 0; m_req = 0; m_done = 0; m_err = 0; m_data = '0;
    samp = {};
    repeat (SS) samp.push_back(1'b0);
    acc_cyc = cyc;
  endtask

  task automatic model_step();
    bit ack_old;
    bit set_err;
    cyc++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ack_old = samp[SS-1];
    samp.push_front(rx_ack);
    void'(samp.pop_back());
    m_done  = 0;
    set_err = 0;
    if (!m_wait) begin
      if (in_valid) begin
        m_wait  = 1;
        m_req   = !m_req;
        m_data  = in_data;
        acc_cyc = cyc;
      end
    end else begin
      if (TO > 0 && (cyc - acc_cyc) >= TO) set_err = 1;
      if (ack_old == m_req) begin
        m_wait = 0;
        m_done = 1;
      end
    end
    if (set_err) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(!m_wait));
    chk("busy",     32'(busy),     32'(m_wait));
    chk("tx_req",   32'(tx_req),   32'(m_req));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("done",     32'(done),     32'(m_done));
    chk("err",      32'(err),      32'(m_err));
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("areset_tx_req",   32'(tx_req),   32'(0));
    chk("areset_in_ready", 32'(in_ready), 32'(1));
    compare_all();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [DW-1:0] words[3] = '{8'h01, 8'h02, 8'h03};
  bit            reqs[$];

  initial begin
    int  idx;
    int  dcnt;
    int  base;
    bit  last_req;
    bit  got;

    model_reset();
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) tick();
    chk("rst_tx_req",   32'(tx_req),   32'(0));
    chk("rst_tx_data",  32'(tx_data),  32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy",     32'(busy),     32'(0));
    chk("rst_err",      32'(err),      32'(0));
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick();

    // Single transfer, ack raised 3 cycles after the request toggle
    auto_ack  = 1'b1;
    ack_delay = 3;
    base      = rx_log.size();
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    tick();
    chk("single_tx_data", 32'(tx_data), 32'(8'hA5));
    chk("single_tx_req",  32'(tx_req),  32'(1));
    chk("single_busy",    32'(busy),    32'(1));
    in_data = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("hold_done",     32'(done),     32'(0));
      chk("hold_tx_data",  32'(tx_data),  32'(8'hA5));
      chk("hold_tx_req",   32'(tx_req),   32'(1));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    tick();
    chk("single_done",     32'(done),     32'(1));
    chk("single_in_ready", 32'(in_ready), 32'(1));
    tick();
    chk("single_done_one", 32'(done), 32'(0));
    chk("single_log_size", 32'(rx_log.size()), 32'(base + 1));
    if (rx_log.size() > base) chk("single_log", 32'(rx_log[base]), 32'(8'hA5));

    // Back-to-back stream with a 2-cycle echo
    pulse_reset();
    ack_delay = 2;
    base      = rx_log.size();
    idx       = 0;
    dcnt      = 0;
    last_req  = tx_req;
    reqs      = {};
    for (int c = 0; c < 120; c++) begin
      if (in_ready) begin
        if (idx < 3) begin
          in_data  = words[idx];
          in_valid = 1'b1;
          idx++;
        end else begin
          in_valid = 1'b0;
          if (dcnt == 3) break;
        end
      end
      tick();
      if (done) dcnt++;
      if (tx_req != last_req) reqs.push_back(tx_req);
      last_req = tx_req;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(idx), 32'(3));
    chk("b2b_dones",   32'(dcnt), 32'(3));
    chk("b2b_toggles", 32'(reqs.size()), 32'(3));
    if (reqs.size() == 3) begin
      chk("b2b_req0", 32'(reqs[0]), 32'(1));
      chk("b2b_req1", 32'(reqs[1]), 32'(0));
      chk("b2b_req2", 32'(reqs[2]), 32'(1));
    end
    chk("b2b_log_size", 32'(rx_log.size()), 32'(base + 3));
    for (int i = 0; i < 3; i++)
      if (rx_log.size() > base + i) chk("b2b_log", 32'(rx_log[base + i]), 32'(words[i]));

    // Watchdog: never ack, err after 10 WAIT cycles, clear only via err_clr
    pulse_reset();
    auto_ack = 1'b0;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) chk("wd_not_yet", 32'(err), 32'(0));
      if (i == 10) begin
        chk("wd_err",  32'(err),  32'(1));
        chk("wd_busy", 32'(busy), 32'(1));
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_set_wins", 32'(err), 32'(1));
    auto_ack  = 1'b1;
    ack_delay = 1;
    got       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("wd_late_done",   32'(got), 32'(1));
    chk("wd_err_sticky",  32'(err), 32'(1));
    tick();
    chk("wd_err_held",    32'(err), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_err_cleared", 32'(err), 32'(0));

    // Spurious ack toggle while idle
    pulse_reset();
    ack_delay = 2;
    spur_req++;
    dcnt = 0;
    repeat (8) begin
      tick();
      if (done) dcnt++;
    end
    chk("spur_idle_nodone", 32'(dcnt), 32'(0));
    chk("spur_rx_ack",      32'(rx_ack), 32'(1));
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("spur_tx_req",  32'(tx_req),  32'(1));
    chk("spur_tx_data", 32'(tx_data), 32'(8'h55));
    tick();
    chk("spur_done_fast", 32'(done), 32'(1));
    dcnt = 0;
    repeat (6) begin
      tick();
      if (done) dcnt++;
    end
    chk("spur_no_extra", 32'(dcnt), 32'(0));

    // Randomized traffic against the model
    pulse_reset();
    for (int n = 0; n < 800; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      err_clr  = ($urandom_range(0, 7) == 0);
      auto_ack = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 15) == 0) ack_delay = $urandom_range(0, 13);
      if ($urandom_range(0, 99) == 0) spur_req++;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      tick();
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
